eprisc_iobus_master: RTL and testbench
======================================

Name: eprisc_iobus_master

Overview:
CPU-side master for the epRISC I/O controller serial byte bus; it sits directly upstream of the controller.
- Accepts one 32-bit command word over a valid/ready handshake.
- Generates the bus clock, select and MOSI byte stream, little-endian (byte0 = bits 7:0).
- Captures the four MISO bytes of the same frame and returns them as a 32-bit response.
- Synchronizes the controller's interrupt line into the iClk domain.

Parameters:
pClkDiv, 2, bus-clock half-period in iClk cycles (≥1); abbreviated H below.

Ports:
iClk  in  1  system clock
iRst  in  1  synchronous reset, active-high
iCmdValid  in  1  command present
oCmdReady  out  1  command accepted when high with iCmdValid
iCmdTarget  in  2  bus select value for the frame (1..3)
iCmdData  in  32  word to shift out
oRspValid  out  1  response present
iRspReady  in  1  response consumed
oRspData  out  32  MISO bytes assembled {b3,b2,b1,b0}
oRspErr  out  1  target 0 rejected
oBusy  out  1  frame in progress
oIrq  out  1  synchronized iBusInterrupt
oBusClock  out  1  bus clock, idle low
oBusSelect  out  2  bus select, idle 0
oBusMOSI  out  8  MOSI byte
iBusMISO  in  8  MISO byte
iBusInterrupt  in  1  controller interrupt (asynchronous)

Behaviour:
- Reset (iRst=1 at posedge iClk): state IDLE; oBusClock=0, oBusSelect=0, oBusMOSI=0, oRspValid=0, oRspData=0, oRspErr=0, oBusy=0, oIrq=0, synchronizer flops=0, oCmdReady=1 from the next cycle.
- Reset mid-frame: outputs return to reset values on the next cycle. No partial response is produced. The next frame's SYNC pulse realigns the controller.
- oCmdReady = (state==IDLE). Only one command is outstanding. iCmdTarget and iCmdData are latched on the accept edge.
- Accept with iCmdTarget==0: no bus activity. Next cycle: oRspValid=1, oRspErr=1, oRspData=0.
- Accept with iCmdTarget≠0: oBusy=1, and the FSM runs SYNC → SETUP → SHIFT → HOLD → RESP.
  - SYNC: select=0, clock high for H cycles then low for H cycles. The controller's state machine returns to its Load state on this edge.
  - SETUP: select=target, clock low, H cycles.
  - SHIFT: six bus-clock pulses e=1..6, each high H cycles then low H cycles.
    - On the cycle the clock rises for e=1..4: oBusMOSI=byte(e-1). MOSI is held stable through the following falling edge, where the controller samples it.
    - After e=4, oBusMOSI holds byte3 until HOLD.
    - In the last iClk cycle of the low phase of pulse e=1..4: capture iBusMISO into byte(e-1) of the response.
    - Pulses 5 and 6 advance the controller through HiHi → Store → Load; its write commits on pulse 6.
  - HOLD: clock low, select=0, oBusMOSI=0, H cycles.
  - RESP: oRspValid=1, oRspErr=0, oBusy=0. oRspData is stable until the handshake iRspValid&&iRspReady (oRspValid && iRspReady), then IDLE.
- Latency: oRspValid rises exactly 16·H+1 iClk cycles after the accept edge. With H=2 that is 33 cycles.
- oCmdReady is low from the accept edge until the cycle after the response handshake. A new command can be accepted in the cycle after the response is consumed.
- oBusClock and oBusSelect are registered outputs and are glitch-free. oBusSelect changes only while oBusClock is low.
- Phase counter: ceil(log2(pClkDiv))+1 bits; pulse counter: 3 bits. Neither wraps within a frame.
- oIrq: 2-flop synchronizer on iBusInterrupt, giving 2-cycle latency. It is independent of the FSM and runs during frames.
- iRspReady held high continuously: the response is consumed in its first valid cycle.
- iCmdValid deasserted without an accept: no effect.

Test Plan:
1. Write frame, H=2, target=1, iCmdData=0x0001_3455 → exactly 7 oBusClock rising edges (1 with select=0, 6 with select=1). MOSI at the falling edges of pulses 1–4 = 55, 34, 01, 00. oRspValid at accept+33.
2. Readback: controller model returns MISO bytes 0xEF, 0xBE, 0xAD, 0xDE in LoLo..HiHi → oRspData=0xDEAD_BEEF, oRspErr=0.
3. Target 0 with data 0x1234_5678 → no oBusClock or oBusSelect activity; next cycle oRspValid=1, oRspErr=1, oRspData=0.
4. Backpressure: iRspReady=0 for 10 cycles after oRspValid → oRspData stable, oCmdReady=0. A second command held valid is accepted only the cycle after the response handshake.
5. iRst asserted during pulse 3 → next cycle oBusClock=0, oBusSelect=0, oRspValid=0. A following write of 0x0001_3455 to target 2 completes correctly on the controller model.
6. iBusInterrupt pulse of 3 cycles, asynchronous to the frame → oIrq high for 3 cycles, starting 2 cycles later, during an active frame; the frame timing is unaffected.

Source files
------------

// File: rtl/eprisc_iobus_master.sv
// CPU-side master for the epRISC I/O controller byte bus: one 32-bit command in,
// a SYNC/SETUP/SHIFT/HOLD bus frame out, and the four captured MISO bytes back.
module eprisc_iobus_master #(
  parameter int pClkDiv = 2
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iCmdValid,
  output logic        oCmdReady,
  input  logic [1:0]  iCmdTarget,
  input  logic [31:0] iCmdData,
  output logic        oRspValid,
  input  logic        iRspReady,
  output logic [31:0] oRspData,
  output logic        oRspErr,
  output logic        oBusy,
  output logic        oIrq,
  output logic        oBusClock,
  output logic [1:0]  oBusSelect,
  output logic [7:0]  oBusMOSI,
  input  logic [7:0]  iBusMISO,
  input  logic        iBusInterrupt
);

  localparam int PW = $clog2(pClkDiv) + 1;
  localparam logic [PW-1:0] H_LAST = PW'(pClkDiv - 1);
  localparam logic [PW-1:0] P_LAST = PW'(2 * pClkDiv - 1);

  typedef enum logic [2:0] {IDLE, SYNC, SETUP, SHIFT, HOLD, RESP} state_t;

  state_t      state, state_d;
  logic [PW-1:0] phase, phase_d;
  logic [2:0]  pulse, pulse_d;
  logic [1:0]  target, target_d;
  logic [31:0] data, data_d;
  logic        bus_clock_d;
  logic [1:0]  sel_d;
  logic [7:0]  mosi_d;
  logic [31:0] rsp_data_d;
  logic        rsp_err_d;
  logic [1:0]  next_byte;
  logic        irq_meta;

  assign next_byte = pulse[1:0] + 2'd1;
  assign oCmdReady = (state == IDLE);
  assign oRspValid = (state == RESP);
  assign oBusy     = (state != IDLE) && (state != RESP);

  // Every bus output is computed here for the following cycle and registered,
  // so oBusClock/oBusSelect/oBusMOSI never glitch.
  always_comb begin
    state_d     = state;
    phase_d     = phase;
    pulse_d     = pulse;
    target_d    = target;
    data_d      = data;
    bus_clock_d = oBusClock;
    sel_d       = oBusSelect;
    mosi_d      = oBusMOSI;
    rsp_data_d  = oRspData;
    rsp_err_d   = oRspErr;
    case (state)
      IDLE: begin
        if (iCmdValid) begin
          target_d   = iCmdTarget;
          data_d     = iCmdData;
          rsp_data_d = '0;
          phase_d    = '0;
          pulse_d    = '0;
          if (iCmdTarget == 2'd0) begin
            state_d   = RESP;
            rsp_err_d = 1'b1;
          end else begin
            state_d     = SYNC;
            rsp_err_d   = 1'b0;
            bus_clock_d = 1'b1;
          end
        end
      end
      SYNC: begin
        phase_d = phase + PW'(1);
        if (phase == H_LAST) bus_clock_d = 1'b0;
        if (phase == P_LAST) begin
          state_d = SETUP;
          phase_d = '0;
          sel_d   = target;
        end
      end
      SETUP: begin
        phase_d = phase + PW'(1);
        if (phase == H_LAST) begin
          state_d     = SHIFT;
          phase_d     = '0;
          bus_clock_d = 1'b1;
          mosi_d      = data[7:0];
        end
      end
      SHIFT: begin
        phase_d = phase + PW'(1);
        if (phase == H_LAST) bus_clock_d = 1'b0;
        if (phase == P_LAST) begin
          phase_d = '0;
          // Last low cycle of pulses 1..4: the controller has its MISO byte up.
          if (pulse < 3'd4) rsp_data_d[{pulse[1:0], 3'b000} +: 8] = iBusMISO;
          if (pulse == 3'd5) begin
            state_d = HOLD;
            sel_d   = 2'd0;
            mosi_d  = 8'd0;
          end else begin
            pulse_d     = pulse + 3'd1;
            bus_clock_d = 1'b1;
            if (pulse < 3'd3) mosi_d = data[{next_byte, 3'b000} +: 8];
          end
        end
      end
      HOLD: begin
        phase_d = phase + PW'(1);
        if (phase == H_LAST) state_d = RESP;
      end
      RESP: begin
        if (iRspReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state      <= IDLE;
      phase      <= '0;
      pulse      <= '0;
      target     <= '0;
      data       <= '0;
      oBusClock  <= 1'b0;
      oBusSelect <= 2'd0;
      oBusMOSI   <= 8'd0;
      oRspData   <= '0;
      oRspErr    <= 1'b0;
    end else begin
      state      <= state_d;
      phase      <= phase_d;
      pulse      <= pulse_d;
      target     <= target_d;
      data       <= data_d;
      oBusClock  <= bus_clock_d;
      oBusSelect <= sel_d;
      oBusMOSI   <= mosi_d;
      oRspData   <= rsp_data_d;
      oRspErr    <= rsp_err_d;
    end
  end

  // Two-flop synchronizer for the controller's asynchronous interrupt.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      irq_meta <= 1'b0;
      oIrq     <= 1'b0;
    end else begin
      irq_meta <= iBusInterrupt;
      oIrq     <= irq_meta;
    end
  end

endmodule

// File: tb/tb_eprisc_iobus_master.sv
// Directed bench for eprisc_iobus_master (H=2) with a small controller model that
// counts bus-clock edges, records MOSI at falling edges and serves MISO bytes.
module tb_eprisc_iobus_master;

  localparam int H = 2;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iCmdValid = 1'b0;
  logic        oCmdReady;
  logic [1:0]  iCmdTarget = 2'd0;
  logic [31:0] iCmdData = 32'd0;
  logic        oRspValid;
  logic        iRspReady = 1'b0;
  logic [31:0] oRspData;
  logic        oRspErr;
  logic        oBusy;
  logic        oIrq;
  logic        oBusClock;
  logic [1:0]  oBusSelect;
  logic [7:0]  oBusMOSI;
  logic [7:0]  iBusMISO = 8'd0;
  logic        iBusInterrupt = 1'b0;

  eprisc_iobus_master #(.pClkDiv(H)) dut (
    .iClk(iClk), .iRst(iRst),
    .iCmdValid(iCmdValid), .oCmdReady(oCmdReady),
    .iCmdTarget(iCmdTarget), .iCmdData(iCmdData),
    .oRspValid(oRspValid), .iRspReady(iRspReady),
    .oRspData(oRspData), .oRspErr(oRspErr),
    .oBusy(oBusy), .oIrq(oIrq),
    .oBusClock(oBusClock), .oBusSelect(oBusSelect),
    .oBusMOSI(oBusMOSI), .iBusMISO(iBusMISO),
    .iBusInterrupt(iBusInterrupt)
  );

  always #5 iClk = ~iClk;

  int vectors = 0;
  int miscompares = 0;

  // Controller model state, observed on the falling iClk edge.
  int          rises0 = 0;
  int          rises1 = 0;
  int          sel_viol = 0;
  int          pulse_idx = 0;
  logic [1:0]  sel_seen = 2'd0;
  logic [31:0] miso_word = 32'd0;
  logic [7:0]  mosi_got [4];
  logic        prev_clk = 1'b0;
  logic [1:0]  prev_sel = 2'd0;

  always @(negedge iClk) begin
    if (!prev_clk && oBusClock) begin
      if (oBusSelect == 2'd0) begin
        rises0++;
        pulse_idx = 0;
      end else begin
        rises1++;
        sel_seen = oBusSelect;
      end
    end
    if (prev_clk && !oBusClock && oBusSelect != 2'd0) begin
      if (pulse_idx < 4) begin
        mosi_got[pulse_idx] = oBusMOSI;
        iBusMISO = miso_word[8*pulse_idx +: 8];
      end
      pulse_idx++;
    end
    if (oBusSelect != prev_sel && (oBusClock || prev_clk)) sel_viol++;
    prev_clk = oBusClock;
    prev_sel = oBusSelect;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input logic [31:0] mw);
    rises0 = 0;
    rises1 = 0;
    sel_viol = 0;
    sel_seen = 2'd0;
    miso_word = mw;
    for (int i = 0; i < 4; i++) mosi_got[i] = 8'hxx;
  endtask

  // Drive a command at the next negedge (ready expected high there).
  task automatic start_cmd(input logic [1:0] t, input logic [31:0] d, input logic [31:0] mw);
    @(negedge iClk);
    model_clear(mw);
    iCmdValid = 1'b1;
    iCmdTarget = t;
    iCmdData = d;
  endtask

  // Called at the first negedge after the accept edge; lat = cycles since accept cycle.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!oRspValid && lat < 200) begin
      @(negedge iClk);
      lat++;
    end
  endtask

  task automatic run_frame(input logic [1:0] t, input logic [31:0] d, input logic [31:0] mw,
                           output int lat);
    start_cmd(t, d, mw);
    @(negedge iClk);
    iCmdValid = 1'b0;
    wait_valid(lat);
  endtask

  task automatic take_rsp();
    iRspReady = 1'b1;
    @(negedge iClk);
    iRspReady = 1'b0;
  endtask

  int lat;
  int lat2;
  int bad_data;
  int bad_ready;
  int n;
  logic [4:0] irq_bits;

  initial begin
    // Reset
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    check("rst_clock", {31'd0, oBusClock}, 32'd0);
    check("rst_select", {30'd0, oBusSelect}, 32'd0);
    check("rst_mosi", {24'd0, oBusMOSI}, 32'd0);
    check("rst_rsp_valid", {31'd0, oRspValid}, 32'd0);
    check("rst_rsp_data", oRspData, 32'd0);
    check("rst_rsp_err", {31'd0, oRspErr}, 32'd0);
    check("rst_busy", {31'd0, oBusy}, 32'd0);
    check("rst_irq", {31'd0, oIrq}, 32'd0);
    iRst = 1'b0;
    @(negedge iClk);
    check("rst_cmd_ready", {31'd0, oCmdReady}, 32'd1);

    // 1/2: write frame to target 1, readback DEADBEEF
    run_frame(2'd1, 32'h0001_3455, 32'hDEAD_BEEF, lat);
    check("t1_latency", lat, 33);
    check("t1_rises_sel0", rises0, 1);
    check("t1_rises_sel1", rises1, 6);
    check("t1_select", {30'd0, sel_seen}, 32'd1);
    check("t1_mosi", {mosi_got[3], mosi_got[2], mosi_got[1], mosi_got[0]}, 32'h0001_3455);
    check("t1_sel_stable", sel_viol, 0);
    check("t2_rsp_data", oRspData, 32'hDEAD_BEEF);
    check("t2_rsp_err", {31'd0, oRspErr}, 32'd0);
    check("t1_busy_resp", {31'd0, oBusy}, 32'd0);
    check("t1_select_idle", {30'd0, oBusSelect}, 32'd0);
    take_rsp();
    check("t1_ready_after", {31'd0, oCmdReady}, 32'd1);

    // 3: target 0 rejected without bus activity
    start_cmd(2'd0, 32'h1234_5678, 32'h0);
    @(negedge iClk);
    iCmdValid = 1'b0;
    check("t3_rsp_valid", {31'd0, oRspValid}, 32'd1);
    check("t3_rsp_err", {31'd0, oRspErr}, 32'd1);
    check("t3_rsp_data", oRspData, 32'd0);
    check("t3_busy", {31'd0, oBusy}, 32'd0);
    take_rsp();
    check("t3_bus_activity", rises0 + rises1 + sel_viol, 0);
    check("t3_select", {30'd0, oBusSelect}, 32'd0);

    // 4: backpressure, second command held valid through the response
    run_frame(2'd3, 32'hA5A5_5A5A, 32'h4433_2211, lat);
    check("t4_latency", lat, 33);
    check("t4_mosi", {mosi_got[3], mosi_got[2], mosi_got[1], mosi_got[0]}, 32'hA5A5_5A5A);
    model_clear(32'h0F0E_0D0C);
    iCmdValid = 1'b1;
    iCmdTarget = 2'd2;
    iCmdData = 32'h0000_0077;
    bad_data = 0;
    bad_ready = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge iClk);
      if (oRspData !== 32'h4433_2211 || !oRspValid) bad_data++;
      if (oCmdReady !== 1'b0 || oBusy !== 1'b0) bad_ready++;
    end
    check("t4_rsp_stable", bad_data, 0);
    check("t4_no_accept", bad_ready, 0);
    iRspReady = 1'b1;
    @(negedge iClk);
    iRspReady = 1'b0;
    check("t4_rsp_dropped", {31'd0, oRspValid}, 32'd0);
    check("t4_ready_after_hs", {31'd0, oCmdReady}, 32'd1);
    check("t4_not_busy_yet", {31'd0, oBusy}, 32'd0);
    @(negedge iClk);
    iCmdValid = 1'b0;
    check("t4_second_accepted", {31'd0, oBusy}, 32'd1);
    wait_valid(lat2);
    check("t4_second_latency", lat2, 33);
    check("t4_second_rsp", oRspData, 32'h0F0E_0D0C);
    check("t4_second_mosi", {mosi_got[3], mosi_got[2], mosi_got[1], mosi_got[0]}, 32'h0000_0077);
    check("t4_second_select", {30'd0, sel_seen}, 32'd2);
    take_rsp();

    // 5: reset during pulse 3, then a clean write to target 2
    start_cmd(2'd1, 32'hFFFF_FFFF, 32'h0);
    @(negedge iClk);
    iCmdValid = 1'b0;
    n = 0;
    while (rises1 < 3 && n < 200) begin
      @(negedge iClk);
      n++;
    end
    check("t5_reached_pulse3", rises1, 3);
    iRst = 1'b1;
    @(negedge iClk);
    iRst = 1'b0;
    check("t5_clock_low", {31'd0, oBusClock}, 32'd0);
    check("t5_select_idle", {30'd0, oBusSelect}, 32'd0);
    check("t5_rsp_valid", {31'd0, oRspValid}, 32'd0);
    check("t5_rsp_data", oRspData, 32'd0);
    check("t5_cmd_ready", {31'd0, oCmdReady}, 32'd1);
    run_frame(2'd2, 32'h0001_3455, 32'h5566_7788, lat);
    check("t5_latency", lat, 33);
    check("t5_rises", rises0 * 16 + rises1, 16 + 6);
    check("t5_select", {30'd0, sel_seen}, 32'd2);
    check("t5_mosi", {mosi_got[3], mosi_got[2], mosi_got[1], mosi_got[0]}, 32'h0001_3455);
    check("t5_rsp_data_ok", oRspData, 32'h5566_7788);
    take_rsp();

    // 6: interrupt pulse during an active frame
    irq_bits = '0;
    fork
      run_frame(2'd1, 32'h0BAD_F00D, 32'h89AB_CDEF, lat);
      begin
        repeat (5) @(negedge iClk);
        iBusInterrupt = 1'b1;
        for (int i = 0; i < 5; i++) begin
          @(negedge iClk);
          irq_bits[i] = oIrq;
          if (i == 2) iBusInterrupt = 1'b0;
        end
      end
    join
    check("t6_irq_pattern", {27'd0, irq_bits}, 32'h0000_000E);
    check("t6_latency", lat, 33);
    check("t6_rsp_data", oRspData, 32'h89AB_CDEF);
    check("t6_mosi", {mosi_got[3], mosi_got[2], mosi_got[1], mosi_got[0]}, 32'h0BAD_F00D);
    check("t6_rises", rises0 * 16 + rises1, 16 + 6);
    take_rsp();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
